// File: rtl/wav_dfi_lp_ctrl_req.sv
`default_nettype none
// ============================================================================
// Module      : wav_dfi_lp_ctrl_req
// Description : MC-side DFI low-power control requester. Drives lp_ctrl_req
//               and lp_ctrl_wakeup toward the PHY, holds the command path idle
//               while a request is outstanding, abandons unanswered requests
//               after TLP_RESP cycles and flags PHY handshake violations.
// Revision    : 1.0 - initial release
// ============================================================================
module wav_dfi_lp_ctrl_req #(
  parameter int TLP_RESP    = 8,   // 1..255
  parameter int TACK_MAX    = 64,  // >= 1
  parameter int HOLDOFF_CYC = 2    // >= 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lp_start,
  input  logic       lp_exit,
  input  logic [5:0] lp_wakeup_code,
  input  logic       cmd_idle,
  input  logic       init_start,
  input  logic       lp_ctrl_ack,
  output logic       lp_ctrl_req,
  output logic [5:0] lp_ctrl_wakeup,
  output logic       cmd_block,
  output logic       lp_active,
  output logic       lp_timeout,
  output logic       protocol_err,
  output logic       busy
);

  // One shared counter serves REQ, EXIT and HOLDOFF; it is cleared on every
  // state change, so it only has to hold the largest of the three limits.
  localparam int c_CNT_MAX_I = (TLP_RESP > TACK_MAX) ?
                               ((TLP_RESP > HOLDOFF_CYC) ? TLP_RESP : HOLDOFF_CYC) :
                               ((TACK_MAX > HOLDOFF_CYC) ? TACK_MAX : HOLDOFF_CYC);
  localparam int c_CNT_W = $clog2(c_CNT_MAX_I + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(c_CNT_MAX_I);
  localparam logic [c_CNT_W-1:0] c_TLP_LAST = c_CNT_W'(TLP_RESP - 1);
  localparam logic [c_CNT_W-1:0] c_ACK_LAST = c_CNT_W'(TACK_MAX - 1);
  localparam logic [c_CNT_W-1:0] c_HLD_LAST = c_CNT_W'(HOLDOFF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_REQ     = 3'd2,
    S_ACTIVE  = 3'd3,
    S_EXIT    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_next;
  logic                 w_cnt_inc;
  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_err_set;

  // Next-state decode; exit/init requests take priority over ack handling.
  always_comb begin
    w_next    = r_state;
    w_cnt_inc = 1'b0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lp_start && !init_start) begin
          w_accept = 1'b1;
          w_next   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // init_start aborts a pending entry before any request is raised
        if (init_start)    w_next = S_HOLDOFF;
        else if (cmd_idle) w_next = S_REQ;
      end
      S_REQ: begin
        if (lp_exit || init_start) begin
          w_next = lp_ctrl_ack ? S_EXIT : S_HOLDOFF;
        end else if (lp_ctrl_ack) begin
          w_next = S_ACTIVE;
        end else if (r_cnt >= c_TLP_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_HOLDOFF;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (lp_exit || init_start) begin
          w_next = S_EXIT;
        end else if (!lp_ctrl_ack) begin
          // PHY withdrew ack while the request was still held
          w_err_set = 1'b1;
          w_next    = S_HOLDOFF;
        end
      end
      S_EXIT: begin
        if (!lp_ctrl_ack) begin
          w_next = S_HOLDOFF;
        end else if (r_cnt >= c_ACK_LAST) begin
          w_err_set = 1'b1;
          w_next    = S_HOLDOFF;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt >= c_HLD_LAST) w_next = S_IDLE;
        else                     w_cnt_inc = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counter clears on each transition and saturates instead of wrapping.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_next != r_state)
      w_cnt_next = '0;
    else if (w_cnt_inc && (r_cnt != c_CNT_MAX))
      w_cnt_next = r_cnt + c_CNT_W'(1);
  end

  // State, counter and outputs register together so outputs match the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      lp_ctrl_req    <= 1'b0;
      lp_ctrl_wakeup <= 6'd0;
      cmd_block      <= 1'b0;
      lp_active      <= 1'b0;
      lp_timeout     <= 1'b0;
      protocol_err   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      lp_ctrl_req  <= (w_next == S_REQ) || (w_next == S_ACTIVE);
      cmd_block    <= (w_next != S_IDLE);
      busy         <= (w_next != S_IDLE);
      lp_active    <= (w_next == S_ACTIVE);
      lp_timeout   <= w_timeout;
      protocol_err <= protocol_err | w_err_set;
      if (w_accept)
        lp_ctrl_wakeup <= lp_wakeup_code;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wav_dfi_lp_ctrl_req.sv
`default_nettype none
// ============================================================================
// Module      : tb_wav_dfi_lp_ctrl_req
// Description : Directed self-checking bench for wav_dfi_lp_ctrl_req.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wav_dfi_lp_ctrl_req;

  logic       clock;
  logic       reset;
  logic       lp_start;
  logic       lp_exit;
  logic [5:0] lp_wakeup_code;
  logic       cmd_idle;
  logic       init_start;
  logic       lp_ctrl_ack;
  logic       lp_ctrl_req;
  logic [5:0] lp_ctrl_wakeup;
  logic       cmd_block;
  logic       lp_active;
  logic       lp_timeout;
  logic       protocol_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  wav_dfi_lp_ctrl_req #(
    .TLP_RESP    (8),
    .TACK_MAX    (64),
    .HOLDOFF_CYC (2)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .lp_start       (lp_start),
    .lp_exit        (lp_exit),
    .lp_wakeup_code (lp_wakeup_code),
    .cmd_idle       (cmd_idle),
    .init_start     (init_start),
    .lp_ctrl_ack    (lp_ctrl_ack),
    .lp_ctrl_req    (lp_ctrl_req),
    .lp_ctrl_wakeup (lp_ctrl_wakeup),
    .cmd_block      (cmd_block),
    .lp_active      (lp_active),
    .lp_timeout     (lp_timeout),
    .protocol_err   (protocol_err),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock; sample and drive 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // lp_start pulse followed by one drain cycle with cmd_idle=1: ends in REQ
  task automatic start_to_req(input logic [5:0] code);
    lp_start = 1'b1;
    lp_wakeup_code = code;
    cmd_idle = 1'b1;
    tick();
    lp_start = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; lp_start = 1'b0; lp_exit = 1'b0; lp_wakeup_code = 6'd0;
    cmd_idle = 1'b1; init_start = 1'b0; lp_ctrl_ack = 1'b0;

    // ---------------- reset state
    tick();
    chk("rst_req",  {31'd0, lp_ctrl_req}, 32'd0);
    chk("rst_wake", {26'd0, lp_ctrl_wakeup}, 32'd0);
    chk("rst_blk",  {31'd0, cmd_block}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err",  {31'd0, protocol_err}, 32'd0);
    reset = 1'b0;
    tick();

    // ---------------- normal cycle
    lp_start = 1'b1; lp_wakeup_code = 6'h0A; cmd_idle = 1'b1;
    tick();
    lp_start = 1'b0;
    chk("n_drain_blk", {31'd0, cmd_block}, 32'd1);
    chk("n_drain_req", {31'd0, lp_ctrl_req}, 32'd0);
    chk("n_wake", {26'd0, lp_ctrl_wakeup}, 32'h0A);
    tick();
    chk("n_req", {31'd0, lp_ctrl_req}, 32'd1);
    tick();
    tick();
    lp_ctrl_ack = 1'b1;
    tick();
    chk("n_active", {31'd0, lp_active}, 32'd1);
    chk("n_req_act", {31'd0, lp_ctrl_req}, 32'd1);
    for (int i = 0; i < 9; i++) tick();
    chk("n_active_hold", {31'd0, lp_active}, 32'd1);
    lp_exit = 1'b1;
    tick();
    lp_exit = 1'b0;
    chk("n_exit_req", {31'd0, lp_ctrl_req}, 32'd0);
    chk("n_exit_act", {31'd0, lp_active}, 32'd0);
    chk("n_exit_blk", {31'd0, cmd_block}, 32'd1);
    tick();
    lp_ctrl_ack = 1'b0;
    tick();
    chk("n_hold1_blk", {31'd0, cmd_block}, 32'd1);
    tick();
    chk("n_hold2_blk", {31'd0, cmd_block}, 32'd1);
    tick();
    chk("n_idle_blk", {31'd0, cmd_block}, 32'd0);
    chk("n_idle_busy", {31'd0, busy}, 32'd0);
    chk("n_err", {31'd0, protocol_err}, 32'd0);
    chk("n_wake_hold", {26'd0, lp_ctrl_wakeup}, 32'h0A);

    // ---------------- timeout: req high exactly 8 cycles
    start_to_req(6'h15);
    chk("t_req0", {31'd0, lp_ctrl_req}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t_req_hi", {31'd0, lp_ctrl_req}, 32'd1);
      chk("t_no_to", {31'd0, lp_timeout}, 32'd0);
    end
    tick();
    chk("t_req_lo", {31'd0, lp_ctrl_req}, 32'd0);
    chk("t_pulse", {31'd0, lp_timeout}, 32'd1);
    chk("t_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t_pulse_end", {31'd0, lp_timeout}, 32'd0);
    chk("t_hold_blk", {31'd0, cmd_block}, 32'd1);
    tick();
    chk("t_idle", {31'd0, busy}, 32'd0);
    chk("t_err", {31'd0, protocol_err}, 32'd0);

    // ---------------- drain gating
    cmd_idle = 1'b0;
    lp_start = 1'b1; lp_wakeup_code = 6'h2C;
    tick();
    lp_start = 1'b0;
    chk("d_blk", {31'd0, cmd_block}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("d_req_lo", {31'd0, lp_ctrl_req}, 32'd0);
      if (i < 4) tick();
    end
    cmd_idle = 1'b1;
    tick();
    chk("d_req_hi", {31'd0, lp_ctrl_req}, 32'd1);
    chk("d_wake", {26'd0, lp_ctrl_wakeup}, 32'h2C);
    lp_exit = 1'b1;
    tick();
    lp_exit = 1'b0;
    chk("d_exit_req", {31'd0, lp_ctrl_req}, 32'd0);
    tick();
    tick();
    chk("d_idle", {31'd0, busy}, 32'd0);

    // ---------------- PHY violation: ack falls in ACTIVE
    start_to_req(6'h01);
    lp_ctrl_ack = 1'b1;
    tick();
    chk("v1_active", {31'd0, lp_active}, 32'd1);
    lp_ctrl_ack = 1'b0;
    tick();
    chk("v1_err", {31'd0, protocol_err}, 32'd1);
    chk("v1_req", {31'd0, lp_ctrl_req}, 32'd0);
    tick();
    tick();
    chk("v1_idle", {31'd0, busy}, 32'd0);
    chk("v1_sticky", {31'd0, protocol_err}, 32'd1);

    // ---------------- PHY violation: ack stuck in EXIT
    do_reset();
    chk("v2_clr", {31'd0, protocol_err}, 32'd0);
    start_to_req(6'h02);
    lp_ctrl_ack = 1'b1;
    tick();
    lp_exit = 1'b1;
    tick();
    lp_exit = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    chk("v2_no_err", {31'd0, protocol_err}, 32'd0);
    chk("v2_exit_blk", {31'd0, cmd_block}, 32'd1);
    tick();
    chk("v2_err", {31'd0, protocol_err}, 32'd1);
    chk("v2_req", {31'd0, lp_ctrl_req}, 32'd0);
    lp_ctrl_ack = 1'b0;
    tick();
    tick();
    chk("v2_idle", {31'd0, busy}, 32'd0);
    chk("v2_sticky", {31'd0, protocol_err}, 32'd1);

    // ---------------- init_start interaction
    do_reset();
    start_to_req(6'h03);
    lp_ctrl_ack = 1'b1;
    tick();
    chk("i_active", {31'd0, lp_active}, 32'd1);
    init_start = 1'b1;
    tick();
    chk("i_req_drop", {31'd0, lp_ctrl_req}, 32'd0);
    lp_ctrl_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("i_idle", {31'd0, busy}, 32'd0);
    lp_start = 1'b1; lp_wakeup_code = 6'h3F;
    tick();
    lp_start = 1'b0;
    chk("i_start_busy", {31'd0, busy}, 32'd0);
    chk("i_start_blk", {31'd0, cmd_block}, 32'd0);
    chk("i_start_wake", {26'd0, lp_ctrl_wakeup}, 32'h03);
    init_start = 1'b0;
    tick();
    chk("i_err", {31'd0, protocol_err}, 32'd0);

    // ---------------- asynchronous reset mid-REQ
    start_to_req(6'h04);
    chk("a_req_pre", {31'd0, lp_ctrl_req}, 32'd1);
    reset = 1'b1;
    #2;
    chk("a_req", {31'd0, lp_ctrl_req}, 32'd0);
    chk("a_blk", {31'd0, cmd_block}, 32'd0);
    chk("a_busy", {31'd0, busy}, 32'd0);
    chk("a_wake", {26'd0, lp_ctrl_wakeup}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
